// File: rtl/swap_monitor_pkg.sv
// Shared types and the expected-value rule for the swap/assignment output checker.
// Both the monitor FSM and any future reference model use exp_next() so they cannot drift.
package swap_mon_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StCheck,
        StDone
    } state_e;

    localparam int unsigned MODE_SWAP = 0;
    localparam int unsigned MODE_COPY = 1;

    // Returns {exp_a, exp_b} for the cycle following the sampled pair.
    function automatic logic [1:0] exp_next(input int unsigned mode,
                                            input logic        prev_a,
                                            input logic        prev_b);
        if (mode == MODE_COPY) begin
            return {prev_b, prev_b};
        end
        return {prev_b, prev_a};
    endfunction

endpackage

// File: rtl/swap_monitor_if.sv
// Bundle of the observed demo-block outputs, the run enable and the checker results.
// master drives stimulus and reads results; slave is the monitor itself.
interface swap_monitor_if #(
    parameter int unsigned CNT_W = 16
);

    logic             en;
    logic             a_o;
    logic             b_o;
    logic             busy;
    logic             done;
    logic             pass;
    logic             fail;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] chk_cnt;
    logic [CNT_W-1:0] first_err;

    modport master (
        output en, a_o, b_o,
        input  busy, done, pass, fail, err_cnt, chk_cnt, first_err
    );

    modport slave (
        input  en, a_o, b_o,
        output busy, done, pass, fail, err_cnt, chk_cnt, first_err
    );

endinterface

// File: rtl/swap_monitor_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q_o = cnt_q;

endmodule

// File: rtl/swap_monitor.sv
// Checks the a_o/b_o sequence of the swap/assignment demo block against the MODE rule and
// reports done/pass/fail, the mismatch count and the index of the first mismatching compare.
module swap_monitor
    import swap_mon_pkg::*;
#(
    parameter int unsigned CHECK_LEN = 16,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned MODE      = MODE_SWAP
) (
    input  logic          clk,
    input  logic          rst,
    swap_monitor_if.slave mon
);

    if ((CHECK_LEN < 1) || (64'(CHECK_LEN) > ((64'd1 << CNT_W) - 64'd1))) begin : g_bad_len
        $error("swap_monitor: CHECK_LEN must be 1..2**CNT_W-1");
    end

    if (MODE > MODE_COPY) begin : g_bad_mode
        $error("swap_monitor: MODE must be 0 (swap) or 1 (copy)");
    end

    state_e           state_q;
    logic             prev_a_q, prev_b_q;
    logic             busy_q, done_q, fail_q;
    logic [CNT_W-1:0] first_err_q;
    logic [CNT_W-1:0] err_cnt, chk_cnt;

    logic [1:0] exp_pair;
    logic       compare;
    logic       mismatch;
    logic       last_cmp;

    always_comb begin
        exp_pair = exp_next(MODE, prev_a_q, prev_b_q);
        compare  = (state_q == StCheck) && mon.en;
        mismatch = compare && ({mon.a_o, mon.b_o} != exp_pair);
        last_cmp = (chk_cnt == CNT_W'(CHECK_LEN - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            prev_a_q    <= 1'b0;
            prev_b_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            first_err_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mon.en) begin
                        prev_a_q <= mon.a_o;
                        prev_b_q <= mon.b_o;
                        busy_q   <= 1'b1;
                        state_q  <= StArm;
                    end
                end
                // Recapture unconditionally so the first compare sees the demo block's
                // settled post-reset value rather than its first edge.
                StArm: begin
                    prev_a_q <= mon.a_o;
                    prev_b_q <= mon.b_o;
                    if (mon.en) begin
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    if (compare) begin
                        prev_a_q <= mon.a_o;
                        prev_b_q <= mon.b_o;
                        if (mismatch && !fail_q) begin
                            fail_q      <= 1'b1;
                            first_err_q <= chk_cnt;
                        end
                        if (last_cmp) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    state_q <= StDone;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    sat_counter #(
        .Width (CNT_W)
    ) u_err_cnt (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (1'b0),
        .inc_i (mismatch),
        .q_o   (err_cnt)
    );

    // CHECK_LEN bounds keep this one from ever reaching its saturation point.
    sat_counter #(
        .Width (CNT_W)
    ) u_chk_cnt (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (1'b0),
        .inc_i (compare),
        .q_o   (chk_cnt)
    );

    assign mon.busy      = busy_q;
    assign mon.done      = done_q;
    assign mon.fail      = fail_q;
    assign mon.pass      = done_q && (err_cnt == '0);
    assign mon.err_cnt   = err_cnt;
    assign mon.chk_cnt   = chk_cnt;
    assign mon.first_err = first_err_q;

endmodule
